four_to_two_encoder: RTL and testbench

Sequential 4-to-2 priority encoder: the encode-side counterpart of the team's 2-to-4 decoder. It captures single-bit event lines D3..D0 into sticky pending bits and presents the highest-priority pending index on Y1/Y0 with a valid/ack handshake. A consumer (typically a two_to_four decoder plus enable) acknowledges each index to retire it. Intended as the event/interrupt front end feeding decoder-addressed logic.

---
 rtl/four_to_two_encoder_if.sv | 40 ++++
 rtl/four_to_two_encoder.sv | 94 +++++++++
 tb/tb_four_to_two_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/four_to_two_encoder_if.sv
// Event/index handshake bundle for four_to_two_encoder.
// The master drives event lines and ack; the slave presents the index.
interface four_to_two_encoder_if;
    logic enable;
    logic D3;
    logic D2;
    logic D1;
    logic D0;
    logic ack;
    logic Y1;
    logic Y0;
    logic valid;
    logic overflow;

    modport master (
        output enable,
        output D3,
        output D2,
        output D1,
        output D0,
        output ack,
        input  Y1,
        input  Y0,
        input  valid,
        input  overflow
    );

    modport slave (
        input  enable,
        input  D3,
        input  D2,
        input  D1,
        input  D0,
        input  ack,
        output Y1,
        output Y0,
        output valid,
        output overflow
    );
endinterface

// File: rtl/four_to_two_encoder.sv
// Sequential 4-to-2 priority encoder with sticky pending events
// and a valid/ack handshake that retires one index per grant.
module four_to_two_encoder (
    input  logic                        clk,
    input  logic                        rst_n,
    four_to_two_encoder_if.slave        bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] cap;
    logic [3:0] clr;
    logic [1:0] idx_q;
    logic [1:0] idx_d;
    logic [1:0] top;
    logic       ovf_q;
    logic       ovf_d;
    logic       retire;

    assign cap = bus.enable ?
                 {bus.D3, bus.D2, bus.D1, bus.D0} :
                 4'b0000;

    assign retire = (state_q == PRESENT) && bus.ack;

    always_comb begin
        clr = 4'b0000;
        if (retire) begin
            clr[idx_q] = 1'b1;
        end
    end

    // Set is applied after clear so an event on its own retire edge survives
    always_comb begin
        pend_d = (pend_q & ~clr) | cap;
        ovf_d  = ovf_q | (|(cap & pend_q));
    end

    always_comb begin
        top = 2'd0;
        unique case (1'b1)
            pend_q[3]:                 top = 2'd3;
            pend_q[3:2] == 2'b01:      top = 2'd2;
            pend_q[3:1] == 3'b001:     top = 2'd1;
            pend_q      == 4'b0001:    top = 2'd0;
            default:                   top = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    idx_d   = top;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            idx_q   <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Y1       = idx_q[1];
    assign bus.Y0       = idx_q[0];
    assign bus.valid    = (state_q == PRESENT);
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Randomized and directed bench for four_to_two_encoder against an
// event-level reference model of pending events and grants.
module tb_four_to_two_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    four_to_two_encoder_if bus ();

    four_to_two_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: set of pending events, the granted index (-1 = none)
    bit [3:0] mp;
    int       mcur;
    bit       movf;

    function automatic void model_reset();
        mp   = 4'b0000;
        mcur = -1;
        movf = 1'b0;
    endfunction

    function automatic void model_edge(bit en, bit [3:0] d, bit a);
        bit [3:0] old;
        old = mp;
        if (mcur >= 0 && a) mp[mcur] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (en && d[i]) begin
                if (old[i]) movf = 1'b1;
                mp[i] = 1'b1;
            end
        end
        if (mcur >= 0) begin
            if (a) mcur = -1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (old[i]) begin
                    mcur = i;
                    break;
                end
            end
        end
    endfunction

    task automatic chk(string tag, logic [31:0] got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare(string tag);
        chk({tag, "_valid"}, 32'(bus.valid), (mcur >= 0) ? 1 : 0);
        chk({tag, "_y"}, 32'({bus.Y1, bus.Y0}), (mcur >= 0) ? mcur : 0);
        chk({tag, "_ovf"}, 32'(bus.overflow), int'(movf));
    endtask

    task automatic cyc(string tag, bit en, bit [3:0] d, bit a);
        bus.enable = en;
        {bus.D3, bus.D2, bus.D1, bus.D0} = d;
        bus.ack = a;
        @(posedge clk);
        if (rst_n) model_edge(en, d, a);
        #1;
        compare(tag);
    endtask

    initial begin
        model_reset();
        bus.enable = 1'b1;
        {bus.D3, bus.D2, bus.D1, bus.D0} = 4'b1111;
        bus.ack = 1'b0;
        #1;
        compare("rst0");

        repeat (3) cyc("rst", 1'b1, 4'b1111, 1'b0);
        #2 rst_n = 1'b1;
        cyc("rel1", 1'b1, 4'b1111, 1'b0);
        chk("rel1_notyet", 32'(bus.valid), 0);
        cyc("rel2", 1'b0, 4'b0000, 1'b0);
        chk("rel2_y11", 32'({bus.Y1, bus.Y0}), 3);
        repeat (9) cyc("drain", 1'b0, 4'b0000, 1'b1);

        cyc("pri", 1'b1, 4'b0110, 1'b0);
        cyc("pri_g1", 1'b0, 4'b0000, 1'b1);
        chk("pri_first", 32'({bus.Y1, bus.Y0}), 2);
        cyc("pri_r1", 1'b0, 4'b0000, 1'b1);
        cyc("pri_g2", 1'b0, 4'b0000, 1'b1);
        chk("pri_second", 32'({bus.Y1, bus.Y0}), 1);
        repeat (3) cyc("pri_end", 1'b0, 4'b0000, 1'b1);

        cyc("np_d0", 1'b1, 4'b0001, 1'b0);
        cyc("np_g0", 1'b0, 4'b0000, 1'b0);
        cyc("np_d3", 1'b1, 4'b1000, 1'b0);
        cyc("np_hold", 1'b0, 4'b0000, 1'b0);
        chk("np_stays00", 32'({bus.Y1, bus.Y0}), 0);
        cyc("np_ack", 1'b0, 4'b0000, 1'b1);
        cyc("np_g3", 1'b0, 4'b0000, 1'b0);
        chk("np_next11", 32'({bus.Y1, bus.Y0}), 3);
        cyc("np_ack3", 1'b0, 4'b0000, 1'b1);
        cyc("np_idle", 1'b0, 4'b0000, 1'b0);

        repeat (3) cyc("en_off", 1'b0, 4'b1111, 1'b0);
        chk("en_off_novalid", 32'(bus.valid), 0);
        cyc("en_on", 1'b1, 4'b0001, 1'b0);
        cyc("en_g", 1'b0, 4'b0000, 1'b1);
        cyc("en_r", 1'b0, 4'b0000, 1'b0);
        repeat (2) cyc("en_idle", 1'b0, 4'b0000, 1'b0);

        cyc("ov_1", 1'b1, 4'b0010, 1'b0);
        cyc("ov_2", 1'b1, 4'b0010, 1'b0);
        chk("ov_set", 32'(bus.overflow), 1);
        cyc("ov_retire", 1'b1, 4'b0010, 1'b1);
        cyc("ov_gap", 1'b0, 4'b0000, 1'b0);
        cyc("ov_again", 1'b0, 4'b0000, 1'b0);
        chk("ov_regrant", 32'({bus.Y1, bus.Y0}), 1);
        cyc("ov_ack", 1'b0, 4'b0000, 1'b1);
        cyc("ov_idle", 1'b0, 4'b0000, 1'b0);

        cyc("mr_ev", 1'b1, 4'b0110, 1'b0);
        cyc("mr_g", 1'b0, 4'b0000, 1'b0);
        cyc("mr_d3", 1'b1, 4'b1000, 1'b0);
        chk("mr_y10", 32'({bus.Y1, bus.Y0}), 2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare("mr_now");
        repeat (2) cyc("mr_hold", 1'b0, 4'b0000, 1'b0);
        #2 rst_n = 1'b1;
        repeat (4) cyc("mr_after", 1'b0, 4'b0000, 1'b0);
        chk("mr_empty", 32'(bus.valid), 0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                compare("rnd_rst");
                #2 rst_n = 1'b1;
            end
            cyc("rnd",
                $urandom_range(0, 3) != 0,
                4'($urandom & $urandom),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
